// File: rtl/modulo_decodificador_unidade_garrafas.sv
// modulo_decodificador_unidade_garrafas
// Receive side of the bottle-unit digit path. It validates the encoded unit
// digit and decodes it into a 1-deep output buffer. It also flags the tens
// carry on a MAX_DIGITO->0 wrap and flags skipped counts.
// Optional feature macro: DEC_UNIDADE_CNT_ERRO_EN (saturating invalid-code counter).
module modulo_decodificador_unidade_garrafas #(
  parameter int MAX_DIGITO = 9,
  parameter int LARG_ERR   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          cdfu,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [3:0]          cdd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                carry_dez,
  output logic                salto,
  output logic                erro_cod,
  output logic [LARG_ERR-1:0] cnt_erro
);

  localparam logic [3:0] MAXD = 4'(MAX_DIGITO);

  typedef enum logic {VAZIO, CHEIO} estado_t;

  estado_t    estado;
  logic [3:0] prev;
  logic       prev_ok;
  logic       aceita;
  logic       cod_ok;

  // Successor of a digit, wrapping at MAX_DIGITO.
  function automatic logic [3:0] proximo(input logic [3:0] d);
    return (d == MAXD) ? 4'd0 : d + 4'd1;
  endfunction

  // The buffer can take a new digit when empty or when it drains this cycle.
  assign in_ready = (estado == VAZIO) | out_ready;
  assign aceita   = in_valid & in_ready;
  assign cod_ok   = (cdfu <= MAXD);

  // Output buffer, sequence tracking and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= VAZIO;
      cdd       <= 4'd0;
      out_valid <= 1'b0;
      carry_dez <= 1'b0;
      salto     <= 1'b0;
      erro_cod  <= 1'b0;
      prev      <= 4'd0;
      prev_ok   <= 1'b0;
    end else begin
      if (aceita && cod_ok) begin
        estado    <= CHEIO;
        out_valid <= 1'b1;
        cdd       <= cdfu;
        carry_dez <= prev_ok && (prev == MAXD) && (cdfu == 4'd0);
        salto     <= prev_ok && (cdfu != prev) && (cdfu != proximo(prev));
        prev      <= cdfu;
        prev_ok   <= 1'b1;
      end else if ((estado == CHEIO) && out_ready) begin
        // Consumer drained the buffer and nothing valid replaced it.
        estado    <= VAZIO;
        out_valid <= 1'b0;
        carry_dez <= 1'b0;
        salto     <= 1'b0;
      end
      if (aceita && !cod_ok)
        erro_cod <= 1'b1;
    end
  end

`ifdef DEC_UNIDADE_CNT_ERRO_EN
  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [LARG_ERR-1:0] sat_inc(input logic [LARG_ERR-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Count of invalid codes accepted, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_erro <= '0;
    else if (aceita && !cod_ok)
      cnt_erro <= sat_inc(cnt_erro);
  end
`else
  assign cnt_erro = '0;
`endif

endmodule

// File: tb/tb_modulo_decodificador_unidade_garrafas.sv
// Testbench for modulo_decodificador_unidade_garrafas: directed scenarios
// followed by random traffic, checked against a queue-based reference model.
module tb_modulo_decodificador_unidade_garrafas;

  localparam int MAXD = 9;
  localparam int LE   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    cdfu;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    cdd;
  logic          out_valid;
  logic          out_ready;
  logic          carry_dez;
  logic          salto;
  logic          erro_cod;
  logic [LE-1:0] cnt_erro;

  modulo_decodificador_unidade_garrafas #(.MAX_DIGITO(MAXD), .LARG_ERR(LE)) dut (
    .clk(clk), .rst_n(rst_n), .cdfu(cdfu), .in_valid(in_valid), .in_ready(in_ready),
    .cdd(cdd), .out_valid(out_valid), .out_ready(out_ready), .carry_dez(carry_dez),
    .salto(salto), .erro_cod(erro_cod), .cnt_erro(cnt_erro)
  );

  always #5 clk = ~clk;

  typedef struct {int d; bit c; bit s;} ent_t;
  ent_t q[$];
  int   m_prev;
  bit   m_ok;
  bit   m_err;
  int   m_cnt;
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int exp_cnt();
`ifdef DEC_UNIDADE_CNT_ERRO_EN
    return (m_cnt > (2**LE) - 1) ? (2**LE) - 1 : m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic check_outputs();
    chk("out_valid", out_valid, (q.size() > 0) ? 1 : 0);
    if (q.size() > 0) begin
      chk("cdd", cdd, q[0].d);
      chk("carry_dez", carry_dez, q[0].c);
      chk("salto", salto, q[0].s);
    end
    chk("erro_cod", erro_cod, m_err);
    chk("cnt_erro", cnt_erro, exp_cnt());
  endtask

  // One clock of traffic: drive, check ready, advance model, check outputs.
  task automatic step(input bit v, input int d, input bit r);
    ent_t e;
    bit   rdy_m;
    bit   acc;
    @(negedge clk);
    in_valid  = v;
    cdfu      = 4'(d);
    out_ready = r;
    #1;
    rdy_m = (q.size() == 0) || r;
    chk("in_ready", in_ready, rdy_m);
    acc = v && rdy_m;
    if (q.size() > 0 && r) q.delete(0);
    if (acc) begin
      if (d <= MAXD) begin
        e.d = d;
        e.c = m_ok && (m_prev == MAXD) && (d == 0);
        e.s = m_ok && (d != m_prev) && (d != (m_prev + 1) % (MAXD + 1));
        q.push_back(e);
        m_prev = d;
        m_ok   = 1'b1;
      end else begin
        m_err = 1'b1;
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Asynchronous reset between clock edges, then release.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_cdd", cdd, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_carry", carry_dez, 0);
    chk("rst_salto", salto, 0);
    chk("rst_erro", erro_cod, 0);
    chk("rst_cnt", cnt_erro, 0);
    q.delete();
    m_prev = 0;
    m_ok   = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    cdfu      = 4'd0;
    out_ready = 1'b1;
    do_reset();

    // 1: first digit
    step(1, 3, 1);
    chk("t1_cdd", cdd, 3);
    chk("t1_salto", salto, 0);

    // 2: back-to-back wrap
    step(1, 7, 1);
    step(1, 8, 1);
    step(1, 9, 1);
    step(1, 0, 1);
    chk("t2_carry", carry_dez, 1);

    // 3: skip then repeat
    step(1, 4, 1);
    step(1, 6, 1);
    chk("t3_salto", salto, 1);
    step(1, 6, 1);
    chk("t3_rep_salto", salto, 0);

    // 4: invalid code dropped, prev preserved
    step(1, 1, 1);
    step(1, 12, 1);
    chk("t4_erro", erro_cod, 1);
    step(1, 2, 1);
    chk("t4_salto", salto, 0);
    step(0, 0, 1);

    // 5: stall then same-edge refill
    step(1, 5, 0);
    for (int i = 0; i < 4; i++) step(1, 7, 0);
    chk("t5_hold", cdd, 5);
    step(1, 6, 1);
    chk("t5_refill", cdd, 6);

    // 6: saturating error count, then async reset mid-stream
    for (int i = 0; i < 5; i++) step(1, 10 + i, 1);
    step(1, 4, 0);
    do_reset();
    step(1, 8, 1);
    chk("t6_first_salto", salto, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15)
        : (($urandom_range(0, 1) == 1) ? (m_prev + 1) % (MAXD + 1) : $urandom_range(0, MAXD));
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
      if (i == 200) do_reset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
